// File: rtl/aes_uart_pkg.sv
// Shared constants, FSM encoding and helpers for the AES result UART link.
// Used by both the FPGA transmitter and the host-side receiver.
package aes_uart_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT    = 8'hA5;
  localparam int unsigned FRAME_PAYLOAD_BYTES = 32;
  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_FRAME_BITS     = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  function automatic logic [7:0] xor_bytes(input logic [255:0] d);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < FRAME_PAYLOAD_BYTES; i++) begin
      x = x ^ d[8*i +: 8];
    end
    return x;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser with baud counter; a new byte accepted at the
// end of a stop bit starts immediately, so consecutive bytes have no gap.
module uart_tx_byte
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_byte_valid,
  output logic       out_byte_ready,
  output logic       out_txd
);

  uart_state_e state, state_next;
  logic [15:0] baud, baud_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [7:0]  shreg, shreg_next;
  logic        txd_next;
  logic        baud_end;
  logic        load;

  assign baud_end       = (baud == 16'(CLK_DIV - 1));
  assign out_byte_ready = (state == IDLE) || (state == STOP && baud_end);
  assign load           = out_byte_ready && in_byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      out_txd <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_cnt <= bit_next;
      shreg   <= shreg_next;
      out_txd <= txd_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = START;
      START:   if (baud_end) state_next = DATA;
      DATA:    if (baud_end && bit_cnt == 3'(UART_DATA_BITS - 1)) state_next = STOP;
      STOP:    if (baud_end) state_next = load ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line value is computed one cycle ahead and registered, keeping out_txd glitch-free.
  always_comb begin
    baud_next  = (state == IDLE || baud_end) ? '0 : baud + 16'd1;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    txd_next   = out_txd;
    case (state)
      IDLE: begin
        if (load) begin
          shreg_next = in_byte;
          bit_next   = '0;
          txd_next   = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          bit_next = '0;
          txd_next = shreg[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
            txd_next = 1'b1;
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shreg_next = {1'b0, shreg[7:1]};
            txd_next   = shreg[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (load) begin
            shreg_next = in_byte;
            bit_next   = '0;
            txd_next   = 1'b0;
          end else begin
            txd_next = 1'b1;
          end
        end
      end
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/aes_result_uart_tx.sv
// Captures AES state and cipherkey and sends them as a header-led 8N1 frame.
// Optional macro AES_TX_CHECKSUM_EN appends an XOR checksum byte over the payload.
module aes_result_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 434,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_state,
  input  logic [127:0] in_cipherkey,
  input  logic         in_valid,
  output logic         out_txd,
  output logic         out_busy,
  output logic         out_done
);

`ifdef AES_TX_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = FRAME_PAYLOAD_BYTES + 2;
`else
  localparam int unsigned FRAME_BYTES = FRAME_PAYLOAD_BYTES + 1;
`endif

  logic [255:0] shadow;
  logic [5:0]   idx;
  logic         accept;
  logic         byte_valid;
  logic         byte_ready;
  logic [7:0]   tx_byte;

  assign accept     = in_valid && !out_busy;
  assign byte_valid = accept || (out_busy && idx < 6'(FRAME_BYTES));

  // The header goes out in the accept cycle itself; idx tracks the next byte to hand over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      idx      <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      out_done <= 1'b0;
      if (accept) begin
        shadow   <= {in_state, in_cipherkey};
        idx      <= 6'd1;
        out_busy <= 1'b1;
      end else if (out_busy && byte_ready) begin
        if (idx < 6'(FRAME_BYTES)) begin
          idx <= idx + 6'd1;
        end else begin
          idx      <= '0;
          out_busy <= 1'b0;
          out_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_byte = HDR_BYTE;
    if (out_busy) begin
      for (int unsigned i = 0; i < FRAME_PAYLOAD_BYTES; i++) begin
        if (idx == 6'(i + 1)) tx_byte = shadow[8*(FRAME_PAYLOAD_BYTES-1-i) +: 8];
      end
`ifdef AES_TX_CHECKSUM_EN
      if (idx == 6'(FRAME_PAYLOAD_BYTES + 1)) tx_byte = xor_bytes(shadow);
`endif
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx_byte (
    .clk           (clk),
    .rst           (rst),
    .in_byte       (tx_byte),
    .in_byte_valid (byte_valid),
    .out_byte_ready(byte_ready),
    .out_txd       (out_txd)
  );

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// Bench for aes_result_uart_tx: line waveform checked byte-by-byte against a
// frame model built from the byte order and 8N1 format; honours AES_TX_CHECKSUM_EN.
module tb_aes_result_uart_tx;

  localparam int unsigned DIV = 4;
  localparam int unsigned LB  = 10 * DIV;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_state;
  logic [127:0] in_cipherkey;
  logic         in_valid;
  logic         out_txd;
  logic         out_busy;
  logic         out_done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  aes_result_uart_tx #(
    .CLK_DIV (DIV),
    .HDR_BYTE(8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_state    (in_state),
    .in_cipherkey(in_cipherkey),
    .in_valid    (in_valid),
    .out_txd     (out_txd),
    .out_busy    (out_busy),
    .out_done    (out_done)
  );

  // One sample per clock: start 0, data LSB first, stop 1, each DIV samples long.
  function automatic logic [LB-1:0] line_bits(input logic [7:0] b);
    logic [9:0]    bits;
    logic [LB-1:0] r;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < LB; j++) r[j] = bits[j / DIV];
    return r;
  endfunction

  task automatic build_expected(input logic [127:0] s, input logic [127:0] k);
    logic [7:0] cs;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) exp_q.push_back(s[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) exp_q.push_back(k[127-8*i -: 8]);
`ifdef AES_TX_CHECKSUM_EN
    cs = 8'h00;
    for (int i = 1; i <= 32; i++) cs = cs ^ exp_q[i];
    exp_q.push_back(cs);
`else
    cs = 8'h00;
`endif
  endtask

  task automatic launch(input logic [127:0] s, input logic [127:0] k);
    in_state     = s;
    in_cipherkey = k;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Entered at the first cycle after accept; returns at the cycle out_done must be high.
  task automatic check_frame(input string name, input int disturb_at);
    logic [LB-1:0] got;
    int busy_low = 0;
    int done_hi  = 0;
    int cyc      = 1;
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int j = 0; j < LB; j++) begin
        got[j] = out_txd;
        if (out_busy !== 1'b1) busy_low++;
        if (out_done !== 1'b0) done_hi++;
        if (cyc == disturb_at) begin
          in_valid     = 1'b1;
          in_state     = {$urandom, $urandom, $urandom, $urandom};
          in_cipherkey = {$urandom, $urandom, $urandom, $urandom};
        end else if (cyc == disturb_at + 1) begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      total++;
      if (got !== line_bits(exp_q[b])) begin
        bad++;
        $display("FAIL %s byte%0d line: got %h want %h (byte %h)", name, b, got, line_bits(exp_q[b]), exp_q[b]);
      end
    end
    total++;
    if (busy_low != 0) begin
      bad++;
      $display("FAIL %s busy_in_frame: low for %0d cycles, want 0", name, busy_low);
    end
    total++;
    if (done_hi != 0) begin
      bad++;
      $display("FAIL %s done_in_frame: high for %0d cycles, want 0", name, done_hi);
    end
    total++;
    if (out_done !== 1'b1 || out_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s completion: done=%b busy=%b want done=1 busy=0", name, out_done, out_busy);
    end
  endtask

  task automatic check_after_done(input string name);
    @(negedge clk);
    total++;
    if (out_done !== 1'b0 || out_txd !== 1'b1) begin
      bad++;
      $display("FAIL %s post_done: done=%b txd=%b want done=0 txd=1", name, out_done, out_txd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    in_cipherkey = '0;
    repeat (3) @(negedge clk);
    total++;
    if (out_txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", out_txd); end
    total++;
    if (out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", out_busy); end
    total++;
    if (out_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", out_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int errs = 0;
    repeat (1000) begin
      if (out_txd !== 1'b1 || out_busy !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL idle_line: %0d bad cycles, want 0", errs); end
  endtask

  task automatic test_known_frame();
    logic [127:0] s = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] k = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    build_expected(s, k);
    launch(s, k);
    check_frame("known", 0);
    check_after_done("known");
  endtask

  task automatic test_random_frames();
    logic [127:0] s, k;
    for (int n = 0; n < 2; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      build_expected(s, k);
      launch(s, k);
      check_frame("random", 0);
      check_after_done("random");
    end
  endtask

  task automatic test_mid_frame_ignore();
    logic [127:0] s = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    int errs = 0;
    build_expected(s, k);
    launch(s, k);
    check_frame("ignore", 500);
    repeat (200) begin
      @(negedge clk);
      if (out_busy !== 1'b0 || out_txd !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL ignore_no_second_frame: %0d busy cycles, want 0", errs); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] s2 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
    build_expected(s1, k1);
    launch(s1, k1);
    check_frame("b2b_first", 0);
    build_expected(s2, k2);
    launch(s2, k2);
    check_frame("b2b_second", 0);
    check_after_done("b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] s = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    launch(s, k);
    // Cycle 410 is data bit 1 of byte 10 (0x99), which is a 0 on the line.
    repeat (409) @(negedge clk);
    total++;
    if (out_txd !== 1'b0) begin bad++; $display("FAIL midrst_pre_txd: got %b want 0", out_txd); end
    rst = 1'b1;
    #1;
    total++;
    if (out_txd !== 1'b1) begin bad++; $display("FAIL midrst_txd: got %b want 1", out_txd); end
    total++;
    if (out_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", out_busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s = {$urandom, $urandom, $urandom, $urandom};
    build_expected(s, k);
    launch(s, k);
    check_frame("after_rst", 0);
    check_after_done("after_rst");
  endtask

  task automatic test_checksum_vector();
`ifdef AES_TX_CHECKSUM_EN
    build_expected(128'h0, 128'h01);
    launch(128'h0, 128'h01);
    check_frame("checksum", 0);
    check_after_done("checksum");
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    in_cipherkey = '0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_known_frame();
    test_random_frames();
    test_mid_frame_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_checksum_vector();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
